multiword_add_seq: RTL and testbench

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

---
 rtl/adder_pkg.sv | 16 +
 rtl/define.v | 6 +
 rtl/multiword_add_seq_word_sel.sv | 25 ++
 rtl/multiword_add_seq.sv | 136 +++++++++++++
 tb/tb_multiword_add_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared FSM state encoding and beat-counter sizing for the multiword adder sequencer.
`include "define.v"

package adder_pkg;

    // Wide enough to index the largest supported operation of 16 beats.
    localparam int BEAT_W    = 4;
    localparam int MAX_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/define.v
// Global adder sizing shared by the multiword adder sequencer and its group adder.
`ifndef ADDER_DEFINE_V
`define ADDER_DEFINE_V
`define INPUTSIZE 8
`define GROUPSIZE 4
`endif

// File: rtl/multiword_add_seq_word_sel.sv
// Selects one INPUTSIZE-wide word out of an N-bit operand by beat index (word 0 = LSBs).
module word_sel
    import adder_pkg::*;
#(
    parameter int INPUTSIZE = 8,
    parameter int WORDS     = 4
) (
    input  logic [INPUTSIZE*WORDS-1:0] vec_i,
    input  logic [BEAT_W-1:0]          beat_i,
    output logic [INPUTSIZE-1:0]       word_o
);

    logic [WORDS-1:0][INPUTSIZE-1:0] words;

    assign words = vec_i;

    // Explicit compare-mux keeps the index width independent of WORDS.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (beat_i == BEAT_W'(i)) word_o = words[i];
        end
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequences an N-bit add over WORDS beats through an external INPUTSIZE-bit group adder.
// Optional subtract mode is enabled by defining ADDSEQ_SUB_EN.
`include "define.v"

module multiword_add_seq
    import adder_pkg::*;
#(
    parameter int INPUTSIZE = `INPUTSIZE,
    parameter int WORDS     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUTSIZE*WORDS-1:0] in_a,
    input  logic [INPUTSIZE*WORDS-1:0] in_b,
    input  logic                       in_cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                       in_sub,
`endif
    output logic [INPUTSIZE-1:0]       add_a,
    output logic [INPUTSIZE-1:0]       add_b,
    output logic                       add_c0,
    input  logic [INPUTSIZE:0]         add_s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INPUTSIZE*WORDS-1:0] out_sum,
    output logic                       out_carry
);

    localparam int N = INPUTSIZE * WORDS;

    state_e                          state_q, state_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic                            carry_q, carry_d;
    logic                            cout_q, cout_d;
    logic                            sub_q, sub_d;
    logic [N-1:0]                    a_q, a_d, b_q, b_d;
    logic [WORDS-1:0][INPUTSIZE-1:0] sum_q, sum_d;
    logic [INPUTSIZE-1:0]            word_a, word_b;
    logic                            sub_w;

`ifdef ADDSEQ_SUB_EN
    assign sub_w = in_sub;
`else
    assign sub_w = 1'b0;
`endif

    word_sel #(.INPUTSIZE(INPUTSIZE), .WORDS(WORDS)) u_sel_a (
        .vec_i  (a_q),
        .beat_i (beat_q),
        .word_o (word_a)
    );

    word_sel #(.INPUTSIZE(INPUTSIZE), .WORDS(WORDS)) u_sel_b (
        .vec_i  (b_q),
        .beat_i (beat_q),
        .word_o (word_b)
    );

    assign out_sum   = sum_q;
    assign out_carry = cout_q;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        sub_d     = sub_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_c0    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = sub_w;
                    // Subtraction is a + ~b + 1, so the incoming carry is forced.
                    carry_d = sub_w ? 1'b1 : in_cin;
                    beat_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                add_a  = word_a;
                add_b  = sub_q ? ~word_b : word_b;
                add_c0 = carry_q;
                for (int i = 0; i < WORDS; i++) begin
                    if (beat_q == BEAT_W'(i)) sum_d[i] = add_s[INPUTSIZE-1:0];
                end
                carry_d = add_s[INPUTSIZE];
                beat_d  = beat_q + 1'b1;
                if (beat_q == BEAT_W'(WORDS - 1)) begin
                    cout_d  = add_s[INPUTSIZE];
                    beat_d  = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed and randomised checks of multiword_add_seq with INPUTSIZE=8, WORDS=4;
// the bench models the downstream group adder itself.
`timescale 1ns/1ps

module tb_multiword_add_seq;

    localparam int IS = 8;
    localparam int WD = 4;
    localparam int N  = IS * WD;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_cin;
    logic [N-1:0]  in_a, in_b;
    logic [IS-1:0] add_a, add_b;
    logic          add_c0;
    logic [IS:0]   add_s;
    logic          out_valid, out_ready, out_carry;
    logic [N-1:0]  out_sum;
`ifdef ADDSEQ_SUB_EN
    logic          in_sub;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{IS{1'b0}}, add_c0};

    multiword_add_seq #(.INPUTSIZE(IS), .WORDS(WD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDSEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c0    (add_c0),
        .add_s     (add_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 100 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) chk("in_ready_tmo", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_tmo", {63'd0, out_valid}, 64'd1);
    endtask

    // One full operation: accept, wait for result, stall, release.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input logic sub, input int stall,
                          output logic [N-1:0] s, output logic c, output int lat);
        in_a = a; in_b = b; in_cin = cin;
`ifdef ADDSEQ_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(lat);
        s = out_sum;
        c = out_carry;
        repeat (stall) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    endfunction

    initial begin
        logic [N-1:0] s, ra, rb;
        logic         c, rc, rs;
        logic [N:0]   e;
        int           lat;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef ADDSEQ_SUB_EN
        in_sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum",   {32'd0, out_sum},   64'd0);
        chk("rst_out_carry", {63'd0, out_carry}, 64'd0);
        chk("rst_add_a",     {56'd0, add_a},     64'd0);
        chk("rst_add_c0",    {63'd0, add_c0},    64'd0);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, s, c, lat);
        chk("inc_sum",   {32'd0, s}, 64'h100);
        chk("inc_carry", {63'd0, c}, 64'd0);
        chk("inc_lat",   64'(lat),   64'd5);
        chk("idle_hold_sum",   {32'd0, out_sum},   64'h100);
        chk("idle_out_valid",  {63'd0, out_valid}, 64'd0);

        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 2, s, c, lat);
        chk("ripple_sum",   {32'd0, s}, 64'h0);
        chk("ripple_carry", {63'd0, c}, 64'd1);

        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 0, s, c, lat);
        chk("mid_sum", {32'd0, s}, 64'h00010000);

        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1, s, c, lat);
        chk("msb_sum",   {32'd0, s}, 64'h1);
        chk("msb_carry", {63'd0, c}, 64'd1);

        // Hold in DONE with a new request pending; it must not be taken.
        in_a = 32'h01020304; in_b = 32'h10203040; in_cin = 1'b0; in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_a = 32'hAAAAAAAA; in_b = 32'h11111111;
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            chk("stall_sum",      {32'd0, out_sum},   64'h11223344);
            chk("stall_in_ready", {63'd0, in_ready},  64'd0);
            chk("stall_valid",    {63'd0, out_valid}, 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rel_in_ready", {63'd0, in_ready},  64'd1);
        chk("rel_valid",    {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("second_acc", {63'd0, in_ready}, 64'd0);
        wait_done(lat);
        chk("second_sum", {32'd0, out_sum}, 64'hBBBBBBBB);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset on the second BUSY edge aborts the operation.
        in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", {63'd0, in_ready},  64'd1);
        chk("abort_valid",    {63'd0, out_valid}, 64'd0);
        chk("abort_sum",      {32'd0, out_sum},   64'd0);
        chk("abort_carry",    {63'd0, out_carry}, 64'd0);
        repeat (8) @(posedge clk);
        #1 chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, s, c, lat);
        chk("post_abort_sum",   {32'd0, s}, 64'h23456789);
        chk("post_abort_carry", {63'd0, c}, 64'd0);

`ifdef ADDSEQ_SUB_EN
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, s, c, lat);
        chk("sub_neg_sum",   {32'd0, s}, 64'hFFFFFFFE);
        chk("sub_neg_carry", {63'd0, c}, 64'd0);
        run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 0, s, c, lat);
        chk("sub_pos_sum",   {32'd0, s}, 64'h2);
        chk("sub_pos_carry", {63'd0, c}, 64'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            e = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, $urandom_range(0, 3), s, c, lat);
            chk("rand_result", {31'd0, c, s}, {31'd0, e});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
